hs_mem_sdpram_ext: RTL and testbench
====================================

# hs_mem_sdpram_ext

Parametrised simple dual-port RAM (1W/1R) for the memory library, for buffers, line stores and FIFO backing storage that need more than a bare array. Adds four things to the basic 1W/1R array:
- byte-lane write enables;
- configurable read latency with a reset-cleared valid pipeline;
- selectable read-during-write behaviour;
- out-of-range address protection for non-power-of-two depths.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write lane
- DATA_DEPTH, 16, number of valid words, 1..1048576
- RD_LATENCY, 1, cycles from ren to rvalid, 1..4
- RDW_MODE, HS_MEM_RDW_OLD, read-during-write policy (hs_mem_rdw_e: HS_MEM_RDW_OLD or HS_MEM_RDW_NEW)
- ADDR_WIDTH (local), $clog2(DATA_DEPTH), minimum 1
- NUM_BYTES (local), DATA_WIDTH / BYTE_WIDTH

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset; clears the read pipeline only, never the array
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data
- wbe  in  NUM_BYTES  byte-lane enables; bit i covers wdata[i*BYTE_WIDTH +: BYTE_WIDTH]
- wen  in  1  write strobe
- raddr  in  ADDR_WIDTH  read address
- ren  in  1  read strobe
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  rdata valid, one-cycle pulse per accepted read
- rerr  out  1  qualifies rvalid: the read address was out of range

## Operation
- Array storage is ceil_to_nxt_pow2(DATA_DEPTH) words. Only the first DATA_DEPTH words are addressable.
- Write: with wen=1 and waddr < DATA_DEPTH, update the lanes whose wbe bit is 1; other lanes keep their value.
- If wen=1 and wbe is all zero, no lane changes.
- If waddr ≥ DATA_DEPTH, the write is dropped silently.
- Read: with ren=1, the array is sampled at raddr in the issue cycle. A read issued in cycle T returns array contents as of T; later writes do not affect it.
- If raddr ≥ DATA_DEPTH, rdata=0 and rerr=1 with the matching rvalid. The array is not accessed.
- Read-during-write applies when wen=ren=1, waddr==raddr and the address is in range:
  - HS_MEM_RDW_OLD returns the pre-write word.
  - HS_MEM_RDW_NEW returns the merged word: written lanes take wdata, unwritten lanes take the old word.
- The read pipeline is RD_LATENCY stages of {valid, err, data}. Stage 1 is the array read and merge; the remaining stages are plain registers.
- rdata holds its last value when no read completes. It changes only on the cycle rvalid=1.
- Back-to-back reads every cycle are fully supported; throughput is one read and one write per cycle.

## Timing
- Reset values: rvalid=0, rerr=0, rdata=0, all pipeline valid bits 0.
- Latency: ren sampled at edge T gives rvalid=1 in the cycle following edge T+RD_LATENCY-1, i.e. RD_LATENCY cycles after issue.
- Write latency: one cycle. A read issued one cycle after a write to the same address sees the new data, in either RDW_MODE.
- Reset asserted mid-operation: all in-flight reads are discarded. rvalid, rerr and rdata go to 0 asynchronously. Array contents are retained.
- First ren after reset deasserts: normal latency, no extra bubble.
- rerr is 0 whenever rvalid is 0.

## Structure
- Shared package hs_mem_pkg (new or extended):
  - typedef enum hs_mem_rdw_e {HS_MEM_RDW_OLD, HS_MEM_RDW_NEW}
  - helper function for byte-lane merge(old, new, be)
- ceil_to_nxt_pow2 is taken from hs_math_basic_pkg.
- One sub-module, hs_mem_rd_pipe: a parametrised delay line (DEPTH, payload width) with reset-cleared valid bits and hold-on-idle data. Used for stages 2..RD_LATENCY.
- Elaboration-time assertions:
  - DATA_WIDTH % BYTE_WIDTH == 0
  - 1 ≤ RD_LATENCY ≤ 4
  - DATA_DEPTH ≥ 1

## Test plan
- Basic read, DATA_WIDTH=32, RD_LATENCY=3: write 0xDEADBEEF to addr 5 with wbe=4'hF, then ren at addr 5 -> rvalid=1 exactly 3 cycles later with rdata=0xDEADBEEF, rerr=0.
- Byte enables: preload addr 2 = 0x11223344, then write 0xAABBCCDD with wbe=4'b0101 -> a later read returns 0x11BB33DD.
- RDW_NEW: addr 7 = 0x00000000; same-cycle wen (wdata=0x12345678, wbe=4'b0011) and ren at addr 7 -> rdata=0x00005678. With RDW_OLD the same stimulus -> 0x00000000. A follow-up read returns 0x00005678 in both modes.
- Out of range, DATA_DEPTH=12: write to addr 13 is dropped; read addr 13 -> rdata=0, rerr=1; read addr 11 -> stored value, rerr=0.
- Reset mid-flight, RD_LATENCY=4: issue reads on 3 consecutive cycles, pulse rst_n low after the second -> no rvalid appears for any of them; outputs are 0. After release, a read of a previously written address returns its pre-reset data.
- Streaming: ren every cycle over addrs 0..15 while writing addrs 16..31 -> 16 consecutive rvalid pulses with in-order data, and no gaps.

Source files
------------

// File: rtl/hs_math_basic_pkg.sv
// Basic elaboration-time math helpers shared across the library.
package hs_math_basic_pkg;

    // Smallest power of two that is >= v (returns 1 for v <= 1).
    function automatic int ceil_to_nxt_pow2(input int v);
        int p;
        p = 1;
        for (int i = 0; i < 31; i++) begin
            if (p < v) p = p * 2;
        end
        return p;
    endfunction

endpackage

// File: rtl/hs_mem_pkg.sv
// Shared types and helpers for the memory library.
package hs_mem_pkg;

    typedef enum logic {
        HS_MEM_RDW_OLD = 1'b0,
        HS_MEM_RDW_NEW = 1'b1
    } hs_mem_rdw_e;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int HS_MEM_MAX_W = 1024;
    localparam int HS_MEM_IDX_W = 10;

    // Byte-lane merge: lanes whose be bit is set take new_word, others keep old_word.
    function automatic logic [HS_MEM_MAX_W-1:0] hs_mem_be_merge(
        input logic [HS_MEM_MAX_W-1:0] old_word,
        input logic [HS_MEM_MAX_W-1:0] new_word,
        input logic [HS_MEM_MAX_W-1:0] be,
        input int                      byte_width
    );
        logic [HS_MEM_MAX_W-1:0] res;
        res = old_word;
        for (int i = 0; i < HS_MEM_MAX_W; i++) begin
            if (be[HS_MEM_IDX_W'(i / byte_width)]) res[HS_MEM_IDX_W'(i)] = new_word[HS_MEM_IDX_W'(i)];
        end
        return res;
    endfunction

endpackage

// File: rtl/hs_mem_rd_pipe.sv
// Delay line for the read return path: valid bits are reset-cleared, payload
// only moves with a valid so the output holds its last value when idle.
module hs_mem_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH == 0) begin : g_bypass
        assign o_valid = i_valid;
        assign o_data  = i_data;
    end else begin : g_pipe
        logic [DEPTH-1:0] r_valid;
        logic [WIDTH-1:0] r_data [DEPTH];

        // Shift valid every cycle; advance payload only behind a valid stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= '0;
                for (int s = 0; s < DEPTH; s++) r_data[s] <= '0;
            end else begin
                r_valid[0] <= i_valid;
                if (i_valid) r_data[0] <= i_data;
                for (int s = 1; s < DEPTH; s++) begin
                    r_valid[s] <= r_valid[s-1];
                    if (r_valid[s-1]) r_data[s] <= r_data[s-1];
                end
            end
        end

        assign o_valid = r_valid[DEPTH-1];
        assign o_data  = r_data[DEPTH-1];
    end

endmodule

// File: rtl/hs_mem_sdpram_ext.sv
// Simple dual-port RAM (1W/1R) with byte-lane writes, configurable read
// latency, selectable read-during-write policy and out-of-range protection.
module hs_mem_sdpram_ext
    import hs_mem_pkg::*;
    import hs_math_basic_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          BYTE_WIDTH = 8,
    parameter int          DATA_DEPTH = 16,
    parameter int          RD_LATENCY = 1,
    parameter hs_mem_rdw_e RDW_MODE   = HS_MEM_RDW_OLD,
    localparam int         ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
    localparam int         NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NUM_BYTES-1:0]  wbe,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rerr
);

    localparam int MEM_WORDS = ceil_to_nxt_pow2(DATA_DEPTH);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_width
        $error("hs_mem_sdpram_ext: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_lat
        $error("hs_mem_sdpram_ext: RD_LATENCY must be in 1..4");
    end
    if (DATA_DEPTH < 1) begin : g_chk_depth
        $error("hs_mem_sdpram_ext: DATA_DEPTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_rdw_hit;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_new;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  r_s1_valid;
    logic                  r_s1_err;
    logic [DATA_WIDTH-1:0] r_s1_data;

    logic                  w_out_valid;
    logic [DATA_WIDTH:0]   w_out_payload;

    assign w_wr_ok   = wen && (int'(waddr) < DATA_DEPTH);
    assign w_rd_ok   = int'(raddr) < DATA_DEPTH;
    assign w_rdw_hit = w_wr_ok && ren && w_rd_ok && (waddr == raddr);

    assign w_rd_old  = r_mem[raddr];
    assign w_rd_new  = DATA_WIDTH'(hs_mem_be_merge(HS_MEM_MAX_W'(w_rd_old),
                                                   HS_MEM_MAX_W'(wdata),
                                                   HS_MEM_MAX_W'(wbe),
                                                   BYTE_WIDTH));
    assign w_rd_word = (RDW_MODE == HS_MEM_RDW_NEW && w_rdw_hit) ? w_rd_new : w_rd_old;

    // Array write: only enabled lanes of an in-range address change.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wbe[b]) r_mem[waddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Stage 1: sample the array (or the merged word) in the issue cycle; out-of-range returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= ren;
            if (ren) begin
                r_s1_err  <= !w_rd_ok;
                r_s1_data <= w_rd_ok ? w_rd_word : '0;
            end
        end
    end

    hs_mem_rd_pipe #(
        .DEPTH (RD_LATENCY - 1),
        .WIDTH (DATA_WIDTH + 1)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_s1_valid),
        .i_data  ({r_s1_err, r_s1_data}),
        .o_valid (w_out_valid),
        .o_data  (w_out_payload)
    );

    // The err bit rides with held data, so gate it to keep rerr low when idle.
    assign rvalid = w_out_valid;
    assign rerr   = w_out_valid & w_out_payload[DATA_WIDTH];
    assign rdata  = w_out_payload[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_hs_mem_sdpram_ext.sv
// Directed bench driving two RAM configurations with shared stimulus:
//   u_a: depth 12, latency 3, read-during-write returns new data
//   u_b: depth 40, latency 4, read-during-write returns old data
module tb_hs_mem_sdpram_ext;
    import hs_mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        wen;
    logic [5:0]  raddr;
    logic        ren;

    logic        wen_a, ren_a;
    logic [31:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, rerr_a, rerr_b;

    int n_checks = 0;
    int n_errors = 0;

    // u_a only sees accesses to addresses 0..15 so high addresses never alias into it.
    assign wen_a = wen & (waddr[5:4] == 2'b00);
    assign ren_a = ren & (raddr[5:4] == 2'b00);

    hs_mem_sdpram_ext #(
        .DATA_WIDTH (32), .BYTE_WIDTH (8), .DATA_DEPTH (12),
        .RD_LATENCY (3),  .RDW_MODE   (HS_MEM_RDW_NEW)
    ) u_a (
        .clk (clk), .rst_n (rst_n),
        .waddr (waddr[3:0]), .wdata (wdata), .wbe (wbe), .wen (wen_a),
        .raddr (raddr[3:0]), .ren (ren_a),
        .rdata (rdata_a), .rvalid (rvalid_a), .rerr (rerr_a)
    );

    hs_mem_sdpram_ext #(
        .DATA_WIDTH (32), .BYTE_WIDTH (8), .DATA_DEPTH (40),
        .RD_LATENCY (4),  .RDW_MODE   (HS_MEM_RDW_OLD)
    ) u_b (
        .clk (clk), .rst_n (rst_n),
        .waddr (waddr), .wdata (wdata), .wbe (wbe), .wen (wen),
        .raddr (raddr), .ren (ren),
        .rdata (rdata_b), .rvalid (rvalid_b), .rerr (rerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        waddr = a; wdata = d; wbe = be; wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    // Issue one read (optionally with a same-cycle write) and check the exact
    // latency profile, data, error flag and hold-after-completion on both DUTs.
    task automatic rd_check(input string tag, input logic [5:0] a,
                            input logic [31:0] ea, input logic erra,
                            input logic [31:0] eb, input logic errb,
                            input logic do_wr, input logic [31:0] wd, input logic [3:0] be);
        logic a_act;
        a_act = (a < 6'd16);
        raddr = a; ren = 1'b1;
        if (do_wr) begin
            waddr = a; wdata = wd; wbe = be; wen = 1'b1;
        end
        tick();
        ren = 1'b0; wen = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check_val({tag, "_vld_a"}, 32'(rvalid_a), 32'(a_act && k == 3));
            check_val({tag, "_vld_b"}, 32'(rvalid_b), 32'(k == 4));
            if (a_act && k >= 3) check_val({tag, "_dat_a"}, rdata_a, ea);
            if (a_act && k == 3) check_val({tag, "_err_a"}, 32'(rerr_a), 32'(erra));
            if (k == 4) begin
                check_val({tag, "_dat_b"}, rdata_b, eb);
                check_val({tag, "_err_b"}, 32'(rerr_b), 32'(errb));
            end
            if (k == 5) begin
                check_val({tag, "_hold_b"}, rdata_b, eb);
                check_val({tag, "_err_idle_a"}, 32'(rerr_a), 32'd0);
                check_val({tag, "_err_idle_b"}, 32'(rerr_b), 32'd0);
            end
            if (k < 5) tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        waddr = '0; wdata = '0; wbe = '0; wen = 1'b0;
        raddr = '0; ren = 1'b0;
        tick();
        tick();
        check_val("rst_vld_a", 32'(rvalid_a), 32'd0);
        check_val("rst_err_a", 32'(rerr_a),   32'd0);
        check_val("rst_dat_a", rdata_a,       32'd0);
        check_val("rst_vld_b", 32'(rvalid_b), 32'd0);
        check_val("rst_err_b", 32'(rerr_b),   32'd0);
        check_val("rst_dat_b", rdata_b,       32'd0);
        rst_n = 1'b1;
        tick();

        // Basic write then read, next cycle (write latency one).
        wr(6'd5, 32'hDEADBEEF, 4'hF);
        rd_check("basic", 6'd5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);

        // Byte-lane enables.
        wr(6'd2, 32'h11223344, 4'hF);
        wr(6'd2, 32'hAABBCCDD, 4'b0101);
        rd_check("be", 6'd2, 32'h11BB33DD, 1'b0, 32'h11BB33DD, 1'b0, 1'b0, '0, '0);

        // All-zero byte enables change nothing.
        wr(6'd2, 32'hFFFFFFFF, 4'b0000);
        rd_check("be0", 6'd2, 32'h11BB33DD, 1'b0, 32'h11BB33DD, 1'b0, 1'b0, '0, '0);

        // Read-during-write: u_a returns merged, u_b returns pre-write.
        wr(6'd7, 32'h00000000, 4'hF);
        rd_check("rdw", 6'd7, 32'h00005678, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h12345678, 4'b0011);
        rd_check("rdw_after", 6'd7, 32'h00005678, 1'b0, 32'h00005678, 1'b0, 1'b0, '0, '0);

        // Out of range for u_a (depth 12), in range for u_b.
        wr(6'd11, 32'h0B0B0B0B, 4'hF);
        wr(6'd13, 32'hCAFEF00D, 4'hF);
        rd_check("oor13", 6'd13, 32'h00000000, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, '0, '0);
        rd_check("in11",  6'd11, 32'h0B0B0B0B, 1'b0, 32'h0B0B0B0B, 1'b0, 1'b0, '0, '0);

        // Streaming: preload 0..15, then read 0..15 every cycle while writing 16..31.
        for (int i = 0; i < 16; i++) wr(6'(i), 32'hC0DE0000 | 32'(i), 4'hF);
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                raddr = 6'(c); ren = 1'b1;
                waddr = 6'(16 + c); wdata = 32'hF00D0000 | 32'(16 + c); wbe = 4'hF; wen = 1'b1;
            end else begin
                ren = 1'b0; wen = 1'b0;
            end
            tick();
            if (c >= 2 && c - 2 < 16) begin
                check_val("strm_vld_a", 32'(rvalid_a), 32'd1);
                check_val("strm_dat_a", rdata_a, (c - 2 < 12) ? (32'hC0DE0000 | 32'(c - 2)) : 32'd0);
                check_val("strm_err_a", 32'(rerr_a), 32'(c - 2 >= 12));
            end else begin
                check_val("strm_idle_a", 32'(rvalid_a), 32'd0);
            end
            if (c >= 3 && c - 3 < 16) begin
                check_val("strm_vld_b", 32'(rvalid_b), 32'd1);
                check_val("strm_dat_b", rdata_b, 32'hC0DE0000 | 32'(c - 3));
            end else begin
                check_val("strm_idle_b", 32'(rvalid_b), 32'd0);
            end
        end
        ren = 1'b0; wen = 1'b0;
        tick();
        rd_check("strm_wr20", 6'd20, 32'd0, 1'b0, 32'hF00D0014, 1'b0, 1'b0, '0, '0);

        // Reset mid-flight: three reads, reset pulsed after the second.
        raddr = 6'd3; ren = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_val("mrst_vld_a", 32'(rvalid_a), 32'd0);
        check_val("mrst_err_a", 32'(rerr_a),   32'd0);
        check_val("mrst_dat_a", rdata_a,       32'd0);
        check_val("mrst_vld_b", 32'(rvalid_b), 32'd0);
        check_val("mrst_err_b", 32'(rerr_b),   32'd0);
        check_val("mrst_dat_b", rdata_b,       32'd0);
        tick();
        ren = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("mrst_none_a", 32'(rvalid_a), 32'd0);
            check_val("mrst_none_b", 32'(rvalid_b), 32'd0);
        end
        rd_check("post_rst", 6'd3, 32'hC0DE0003, 1'b0, 32'hC0DE0003, 1'b0, 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
